// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the streaming 2D convolution engine.
package conv_pkg;

  typedef enum logic [1:0] {EMPTY, LOAD, STREAM} state_t;

  // Exact accumulator width: unsigned pixel times signed weight, summed K*K times.
  function automatic int acc_width(input int dw, input int ww, input int k);
    return dw + ww + $clog2(k * k) + 1;
  endfunction

  function automatic logic [63:0] shift_clamp(input logic signed [63:0] acc,
                                              input int shift, input int dw);
    logic signed [63:0] s;
    logic signed [63:0] maxv;
    s    = acc >>> shift;
    maxv = (64'sd1 <<< dw) - 64'sd1;
    if (s < 64'sd0) return '0;
    if (s > maxv)   return maxv;
    return s;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Raster-order pixel delay line exposing a K x K window that already includes the
// pixel being accepted this cycle, so the window completes on the accepting edge.
module conv_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 8,
  parameter int K          = 3
) (
  input  logic                              clock,
  input  logic                              shift_en,
  input  logic [DATA_WIDTH-1:0]             din,
  output logic [K*K-1:0][DATA_WIDTH-1:0]    win
);
  // The live input supplies tap 0, so storage only needs the older taps.
  localparam int DEPTH = (K - 1) * IMG_WIDTH + K - 1;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;

  always_ff @(posedge clock) begin
    if (shift_en) mem_q <= {mem_q[DEPTH-2:0], din};
  end

  for (genvar i = 0; i < K; i++) begin : g_row
    for (genvar j = 0; j < K; j++) begin : g_col
      localparam int D = (K - 1 - i) * IMG_WIDTH + (K - 1 - j);
      if (D == 0) begin : g_live
        assign win[i*K+j] = din;
      end else begin : g_tap
        assign win[i*K+j] = mem_q[D-1];
      end
    end
  end

endmodule

// File: rtl/conv2d_stream_kernel.sv
// Streaming valid-mode K x K convolution: weight-load FSM, frame counters, MAC tree,
// shift/clamp and a single output register with valid/ready handshakes.
module conv2d_stream_kernel
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int IMG_WIDTH    = 8,
  parameter int IMG_HEIGHT   = 8,
  parameter int K            = 3,
  parameter int SHIFT        = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    weight_start,
  input  logic                    weight_valid,
  output logic                    weight_ready,
  input  logic [WEIGHT_WIDTH-1:0] weight_in,
  output logic                    weights_loaded,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_pixel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_pixel,
  output logic                    out_last
);
  localparam int ACC_W = acc_width(DATA_WIDTH, WEIGHT_WIDTH, K);
  localparam int NW    = K * K;
  localparam int WI_W  = $clog2(NW);
  localparam int CW    = $clog2(IMG_WIDTH);
  localparam int RW    = $clog2(IMG_HEIGHT);

  state_t                             state_q;
  logic                               reload_q;
  logic [WI_W-1:0]                    widx_q;
  logic [NW-1:0][WEIGHT_WIDTH-1:0]    w_q;
  logic [RW-1:0]                      row_q, row_d;
  logic [CW-1:0]                      col_q, col_d;
  logic                               out_valid_q, out_last_q;
  logic [DATA_WIDTH-1:0]              out_pixel_q;

  logic [NW-1:0][DATA_WIDTH-1:0]      win;
  logic signed [ACC_W-1:0]            acc;
  logic [DATA_WIDTH-1:0]              result;
  logic frame_start, out_free, accept, win_done, frame_end;

  assign frame_start = (row_q == '0) && (col_q == '0);
  assign out_free    = !out_valid_q || out_ready;
  // A pending reload parks the stream at the frame boundary.
  assign in_ready    = (state_q == STREAM) && out_free && !(reload_q && frame_start);
  assign accept      = in_valid && in_ready;
  assign win_done    = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
  assign frame_end   = (row_q == RW'(IMG_HEIGHT - 1)) && (col_q == CW'(IMG_WIDTH - 1));

  assign weight_ready   = (state_q == LOAD);
  assign weights_loaded = (state_q == STREAM);
  assign out_valid      = out_valid_q;
  assign out_pixel      = out_pixel_q;
  assign out_last       = out_last_q;

  conv_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMG_WIDTH  (IMG_WIDTH),
    .K          (K)
  ) u_lb (
    .clock    (clock),
    .shift_en (accept),
    .din      (in_pixel),
    .win      (win)
  );

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_HEIGHT - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < NW; k++)
      acc = acc + ACC_W'($signed({1'b0, win[k]})) * ACC_W'($signed(w_q[k]));
  end

  assign result = DATA_WIDTH'(shift_clamp(64'(acc), SHIFT, DATA_WIDTH));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      reload_q    <= 1'b0;
      widx_q      <= '0;
      w_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;

      // A new result overwrites a draining one, sustaining one pixel per cycle.
      if (accept && win_done) begin
        out_valid_q <= 1'b1;
        out_pixel_q <= result;
        out_last_q  <= frame_end;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        EMPTY: if (weight_start) begin
          state_q <= LOAD;
          widx_q  <= '0;
        end
        LOAD: if (weight_valid) begin
          w_q[widx_q] <= weight_in;
          widx_q      <= widx_q + WI_W'(1);
          if (widx_q == WI_W'(NW - 1)) state_q <= STREAM;
        end
        STREAM: begin
          if (reload_q && frame_start && out_free) begin
            state_q  <= LOAD;
            reload_q <= 1'b0;
            widx_q   <= '0;
          end else if (weight_start) begin
            reload_q <= 1'b1;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_stream_kernel.sv
// Two engines (SHIFT=0 and SHIFT=3) share one stimulus stream; outputs are checked
// against a whole-frame arithmetic reference held in expected-result queues.
module tb_conv2d_stream_kernel;
  localparam int W = 8, H = 8, K = 3, NPIX = W * H;

  logic clock = 1'b0;
  logic reset, weight_start, weight_valid, in_valid, out_ready;
  logic [7:0] weight_in, in_pixel;
  logic weight_ready, weights_loaded, in_ready, out_valid, out_last;
  logic [7:0] out_pixel;
  logic weight_ready3, weights_loaded3, in_ready3, out_valid3, out_last3;
  logic [7:0] out_pixel3;

  int total = 0, bad = 0;
  int img[NPIX];
  int wt[K*K];
  logic [8:0] exp0_q[$], exp3_q[$];
  logic [7:0] held;

  always #5 clock = ~clock;

  conv2d_stream_kernel #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H),
                         .K(K), .SHIFT(0)) u_dut (
    .clock(clock), .reset(reset), .weight_start(weight_start), .weight_valid(weight_valid),
    .weight_ready(weight_ready), .weight_in(weight_in), .weights_loaded(weights_loaded),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel), .out_valid(out_valid),
    .out_ready(out_ready), .out_pixel(out_pixel), .out_last(out_last));

  conv2d_stream_kernel #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H),
                         .K(K), .SHIFT(3)) u_dut3 (
    .clock(clock), .reset(reset), .weight_start(weight_start), .weight_valid(weight_valid),
    .weight_ready(weight_ready3), .weight_in(weight_in), .weights_loaded(weights_loaded3),
    .in_valid(in_valid), .in_ready(in_ready3), .in_pixel(in_pixel), .out_valid(out_valid3),
    .out_ready(out_ready), .out_pixel(out_pixel3), .out_last(out_last3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] clampv(input int v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return 8'(v);
  endfunction

  // Reference: every full window of the current image against the current weights.
  task automatic expect_frame();
    int acc;
    logic lst;
    for (int r = K - 1; r < H; r++) begin
      for (int c = K - 1; c < W; c++) begin
        acc = 0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            acc += img[(r - K + 1 + i) * W + (c - K + 1 + j)] * wt[i * K + j];
        lst = (r == H - 1) && (c == W - 1);
        exp0_q.push_back({lst, clampv(acc)});
        exp3_q.push_back({lst, clampv(acc >>> 3)});
      end
    end
  endtask

  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      total++;
      assert (exp0_q.size() != 0) else begin
        bad++;
        $error("FAIL out0_extra: observed=%0h expected=none", {out_last, out_pixel});
      end
      if (exp0_q.size() != 0) check("out0", {out_last, out_pixel}, exp0_q.pop_front());
    end
    if (!reset && out_valid3 && out_ready) begin
      total++;
      assert (exp3_q.size() != 0) else begin
        bad++;
        $error("FAIL out3_extra: observed=%0h expected=none", {out_last3, out_pixel3});
      end
      if (exp3_q.size() != 0) check("out3", {out_last3, out_pixel3}, exp3_q.pop_front());
    end
  end

  // Entry and exit at 1 time unit after a rising edge.
  task automatic push_pixel(input int p, input bit fast);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_pixel = 8'(p);
    @(negedge clock);
    while (!in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("in_wait", n < 200, 1);
    if (fast) check("in_fast", n, 0);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int stall_at, input int wstart_at);
    for (int p = 0; p < NPIX; p++) begin
      if (p == wstart_at) weight_start = 1'b1;
      if (p == stall_at) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pixel  = 8'(img[p]);
        for (int s = 0; s < 5; s++) begin
          @(negedge clock);
          if (s == 0) held = out_pixel;
          check("stall_in_ready", in_ready, 0);
          check("stall_valid", out_valid, 1);
          check("stall_hold", out_pixel, held);
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
      end
      push_pixel(img[p], 1'b1);
      weight_start = 1'b0;
    end
  endtask

  task automatic load_weights(input bit pulse);
    int n;
    n = 0;
    if (pulse) begin
      weight_start = 1'b1;
      @(posedge clock); #1;
      weight_start = 1'b0;
    end
    @(negedge clock);
    while (!weight_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("wload_wait", n < 100, 1);
    check("wload_not_loaded", weights_loaded, 0);
    for (int k = 0; k < K * K; k++) begin
      weight_valid = 1'b1;
      weight_in    = 8'(wt[k]);
      @(posedge clock); #1;
    end
    weight_valid = 1'b0;
    check("wload_done", weights_loaded, 1);
    check("wload_ready_low", weight_ready, 0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp0_q.size() != 0 || exp3_q.size() != 0) && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("drain_q0", exp0_q.size(), 0);
    check("drain_q3", exp3_q.size(), 0);
    @(posedge clock); #1;
  endtask

  task automatic rand_img(input int lo, input int hi);
    for (int p = 0; p < NPIX; p++) img[p] = int'($urandom_range(hi, lo));
  endtask

  task automatic rand_wt();
    for (int k = 0; k < K * K; k++) wt[k] = int'($urandom_range(16)) - 8;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; weight_start = 1'b0; weight_valid = 1'b0; weight_in = '0;
    in_valid = 1'b0; in_pixel = '0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pixel", out_pixel, 0);
    check("rst_out_last", out_last, 0);
    check("rst_weight_ready", weight_ready, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_loaded", weights_loaded, 0);
    check("rst3_ctrl", {weight_ready3, weights_loaded3, in_ready3, out_valid3}, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("empty_in_ready", in_ready, 0);
    @(posedge clock); #1;

    // Identity kernel over a ramp: centre pixels pass straight through.
    for (int k = 0; k < K * K; k++) wt[k] = (k == 4) ? 1 : 0;
    load_weights(1'b1);
    for (int p = 0; p < NPIX; p++) img[p] = p;
    expect_frame();
    send_frame(-1, -1);
    wait_drain();

    // Saturation high, saturation low, and a shifted sum.
    for (int k = 0; k < K * K; k++) wt[k] = 1;
    load_weights(1'b1);
    for (int p = 0; p < NPIX; p++) img[p] = 255;
    expect_frame();
    send_frame(-1, -1);
    for (int k = 0; k < K * K; k++) wt[k] = -1;
    load_weights(1'b1);
    for (int p = 0; p < NPIX; p++) img[p] = 10;
    expect_frame();
    send_frame(-1, -1);
    for (int k = 0; k < K * K; k++) wt[k] = 1;
    load_weights(1'b1);
    for (int p = 0; p < NPIX; p++) img[p] = 8;
    expect_frame();
    send_frame(-1, -1);
    wait_drain();

    // Random kernel, output stall mid-frame, then the same frame back-to-back.
    rand_wt();
    load_weights(1'b1);
    rand_img(0, 255);
    expect_frame();
    expect_frame();
    send_frame(30, -1);
    send_frame(-1, -1);
    wait_drain();

    // Reload requested mid-frame takes effect only at the next frame boundary.
    rand_img(0, 255);
    expect_frame();
    send_frame(-1, 20);
    @(negedge clock);
    check("reload_in_ready", in_ready, 0);
    @(posedge clock); #1;
    rand_wt();
    load_weights(1'b0);
    rand_img(0, 255);
    expect_frame();
    send_frame(-1, -1);
    wait_drain();

    // Asynchronous reset mid-frame, then reload and a clean frame.
    rand_wt();
    load_weights(1'b1);
    rand_img(0, 255);
    expect_frame();
    for (int p = 0; p < 35; p++) push_pixel(img[p], 1'b1);
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_in_ready", in_ready, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_loaded", weights_loaded, 0);
    check("mid_rst3_loaded", weights_loaded3, 0);
    exp0_q.delete();
    exp3_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    rand_wt();
    load_weights(1'b1);
    rand_img(0, 255);
    expect_frame();
    send_frame(-1, -1);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
